boot_word_packer: RTL and testbench
===================================

# boot_word_packer

Upstream feeder for the ROM loader. It takes the cartridge image as a byte stream from the file/SPI reader and packs each four bytes into one 32-bit word, first byte in bits [31:24]. It presents each word on the `host_bootdata` four-phase req/ack bus and pads the final partial word. It also drives `host_bootdata_reset` at load start and holds `host_bootdata_size` stable for the whole load.

## Interface
Parameters:
- `PAD_BYTE`, default 8'hFF: fill value for the unused lanes of the final word.
- `RESET_CYCLES`, default 4: width in clocks of the `host_bootdata_reset` pulse (≥1).
- `ACK_TIMEOUT`, default 16'hFFFF: maximum clocks spent in any single handshake wait before the block declares an error.

Ports:
- `clk`  in  1  system clock. One clock only.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle pulse that begins a load.
- `file_size`  in  16  image size in bytes; sampled on `start`.
- `byte_data`  in  8  stream byte.
- `byte_valid`  in  1  `byte_data` is valid.
- `byte_ready`  out  1  block accepts a byte this cycle.
- `host_bootdata`  out  32  packed word (registered).
- `host_bootdata_req`  out  1  word valid request.
- `host_bootdata_ack`  in  1  loader acknowledge.
- `host_bootdata_reset`  out  1  loader reset pulse.
- `host_bootdata_size`  out  16  latched `file_size`.
- `busy`  out  1  load in progress.
- `done`  out  1  last word acknowledged; sticky until the next `start`.
- `error`  out  1  size zero or ack timeout; sticky until the next `start`.

## Operation
- Reset values of all outputs: 0, except `host_bootdata_size` = 0 and `host_bootdata` = 0.
- States:
  - IDLE: waits for `start`.
  - RST: drives `host_bootdata_reset` = 1 for RESET_CYCLES clocks.
  - FILL: accepts bytes.
  - REQ: `host_bootdata_req` = 1; waits for `host_bootdata_ack` = 1.
  - REL: `host_bootdata_req` = 0; waits for `host_bootdata_ack` = 0.
  - DONE.
  - ERR.
- `start` is honoured only in IDLE, DONE or ERR; it is ignored otherwise.
- On `start`:
  - latch `file_size` into `host_bootdata_size` and into a 16-bit `remaining` counter;
  - clear `done`, `error` and the lane counter;
  - go to RST, or to ERR if `file_size` = 0.
- FILL:
  - `byte_ready` = 1.
  - On `byte_valid && byte_ready`, write the byte to lane (3 − lane), i.e. lane 0 → [31:24]; increment lane (2-bit, wraps); decrement `remaining`.
  - Go to REQ after the accept that fills lane 3, or after the accept that makes `remaining` = 0.
  - In the second case, lanes not yet written are forced to PAD_BYTE in the same edge.
- REL exit:
  - if `remaining` = 0, go to DONE (`done` = 1);
  - otherwise go to FILL with the word register preset to {4{PAD_BYTE}}.
- `busy` = 1 in RST, FILL, REQ and REL.
- Timeout:
  - a 16-bit wait counter clears on entry to REQ and REL and increments each clock spent in them;
  - reaching ACK_TIMEOUT → ERR.
  - ERR: `req` = 0, `byte_ready` = 0, `error` = 1.
- `host_bootdata` and `host_bootdata_size` must not change while `req` = 1 or while the ack is outstanding.
- Asynchronous `reset_n` assertion in any state returns the block to IDLE with reset output values immediately, with no handshake completion. Upstream must re-`start`.

## Timing
- `start` sampled at edge k:
  - `host_bootdata_reset` = 1 from after edge k until after edge k+RESET_CYCLES;
  - `byte_ready` = 1 from after edge k+RESET_CYCLES.
- With `byte_valid` held high, four bytes are accepted on four consecutive edges. `req` rises after the edge that accepts the fourth byte (0-cycle bubble).
- `req` falls one clock after `ack` is first sampled high. The next FILL starts one clock after `ack` is sampled low.
- `ack` high on the same edge that `req` rises is impossible by protocol. If `ack` is already high on entry to REQ, it counts as acknowledge (no glitch filter).

## Structure
- Shared package `boot_pkg`: state enum (IDLE, RST, FILL, REQ, REL, DONE, ERR) and the default PAD_BYTE constant, so the loader bench reuses them.
- One natural sub-module, `boot_lane_pack`: the 32-bit word register plus 2-bit lane counter, with write-byte, pad-remaining and preset controls.

## Test plan
- `file_size` = 8, bytes 01..08 continuous, loader-model ack → words 0x01020304 then 0x05060708; `done` = 1; `busy` = 0; `host_bootdata_size` = 8.
- `file_size` = 6, bytes 01..06 → second word 0x0506FFFF; exactly 2 req pulses.
- `byte_valid` toggling every other cycle; ack delayed 20 clocks → `host_bootdata` constant while `req` = 1; no byte accepted outside FILL.
- ACK_TIMEOUT = 16, ack tied low → `error` = 1 exactly 16 clocks after `req` rises; `req` = 0; `byte_ready` = 0.
- `reset_n` pulled low mid-REQ → `req`, `busy` and `byte_ready` drop without waiting for a clock; after release, state is IDLE and a new `start` completes normally.
- `start` with `file_size` = 0 → `error` = 1, no `host_bootdata_reset` pulse. A second `start` pulse during an active load is ignored (latched size unchanged).

Source files
------------

// File: rtl/boot_pkg.sv
// Shared definitions for the boot word packer and the ROM loader bench:
// controller state encoding, default pad byte and lane helpers.
package boot_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RST  = 3'd1,
        ST_FILL = 3'd2,
        ST_REQ  = 3'd3,
        ST_REL  = 3'd4,
        ST_DONE = 3'd5,
        ST_ERR  = 3'd6
    } boot_state_e;

    localparam logic [7:0] BOOT_PAD_BYTE = 8'hFF;
    localparam logic [1:0] LANE_LAST     = 2'd3;

    // Replicate one byte into every lane of a 32-bit word.
    function automatic logic [31:0] lane_fill(input logic [7:0] b);
        return {4{b}};
    endfunction

endpackage

// File: rtl/boot_lane_pack.sv
// Word assembly register: a 32-bit word plus a 2-bit lane pointer.
// Lane 0 lives in bits [31:24]. Supports writing one byte into the current
// lane, padding the lanes above it in the same edge, presetting the whole
// word to pad bytes, and clearing the lane pointer.
module boot_lane_pack
    import boot_pkg::*;
#(
    parameter logic [7:0] PAD_BYTE = BOOT_PAD_BYTE
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clr_lane_i,
    input  logic        preset_i,
    input  logic        wr_en_i,
    input  logic        pad_rest_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic [1:0]  lane_o
);

    logic [31:0] word_q, word_d;
    logic [1:0]  lane_q, lane_d;

    // Next word/lane: preset wins, then lane clear, then byte write with optional padding.
    always_comb begin
        word_d = word_q;
        lane_d = lane_q;
        if (preset_i) begin
            word_d = lane_fill(PAD_BYTE);
            lane_d = 2'd0;
        end else if (clr_lane_i) begin
            word_d = word_q;
            lane_d = 2'd0;
        end else if (wr_en_i) begin
            for (int i = 0; i < 4; i++) begin
                if (2'(i) == lane_q) begin
                    word_d[8*(3-i) +: 8] = byte_i;
                end else if (pad_rest_i && (2'(i) > lane_q)) begin
                    word_d[8*(3-i) +: 8] = PAD_BYTE;
                end else begin
                    word_d[8*(3-i) +: 8] = word_q[8*(3-i) +: 8];
                end
            end
            lane_d = lane_q + 2'd1;
        end else begin
            word_d = word_q;
            lane_d = lane_q;
        end
    end

    // Word and lane registers, cleared asynchronously.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            word_q <= 32'd0;
            lane_q <= 2'd0;
        end else begin
            word_q <= word_d;
            lane_q <= lane_d;
        end
    end

    assign word_o = word_q;
    assign lane_o = lane_q;

endmodule

// File: rtl/boot_word_packer.sv
// Boot word packer: packs a byte stream into big-endian 32-bit words and
// hands each word to the ROM loader over a four-phase req/ack handshake.
// A reset pulse precedes every load, the final word is padded, and every
// handshake wait is guarded by a timeout that ends the load in error.
module boot_word_packer
    import boot_pkg::*;
#(
    parameter logic [7:0]  PAD_BYTE     = BOOT_PAD_BYTE,
    parameter int          RESET_CYCLES = 4,
    parameter logic [15:0] ACK_TIMEOUT  = 16'hFFFF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] file_size,
    input  logic [7:0]  byte_data,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic [31:0] host_bootdata,
    output logic        host_bootdata_req,
    input  logic        host_bootdata_ack,
    output logic        host_bootdata_reset,
    output logic [15:0] host_bootdata_size,
    output logic        busy,
    output logic        done,
    output logic        error
);

    // Reset pulse counter load value and last permitted wait count.
    localparam logic [15:0] RST_LOAD  = 16'(RESET_CYCLES - 1);
    localparam logic [15:0] ACK_LIMIT = ACK_TIMEOUT - 16'd1;

    boot_state_e state_q, state_d;
    logic [15:0] remaining_q, remaining_d;
    logic [15:0] wait_q, wait_d;
    logic [15:0] rst_cnt_q, rst_cnt_d;
    logic [15:0] size_q, size_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
    logic        req_q, ready_q, rst_out_q, busy_q;

    logic        lp_clr_s, lp_preset_s, lp_wr_s, lp_pad_s;
    logic [31:0] word_s;
    logic [1:0]  lane_s;
    logic        start_ok_s;

    // A new load may only begin from a quiescent state.
    assign start_ok_s = start && ((state_q == ST_IDLE) || (state_q == ST_DONE) ||
                                  (state_q == ST_ERR));

    boot_lane_pack #(
        .PAD_BYTE (PAD_BYTE)
    ) u_lane_pack (
        .clk        (clk),
        .reset_n    (reset_n),
        .clr_lane_i (lp_clr_s),
        .preset_i   (lp_preset_s),
        .wr_en_i    (lp_wr_s),
        .pad_rest_i (lp_pad_s),
        .byte_i     (byte_data),
        .word_o     (word_s),
        .lane_o     (lane_s)
    );

    // Load sequencing: reset pulse, byte fill, handshake, completion or error.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        wait_d      = wait_q;
        rst_cnt_d   = rst_cnt_q;
        size_d      = size_q;
        done_d      = done_q;
        error_d     = error_q;
        lp_clr_s    = 1'b0;
        lp_preset_s = 1'b0;
        lp_wr_s     = 1'b0;
        lp_pad_s    = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start_ok_s) begin
                    size_d      = file_size;
                    remaining_d = file_size;
                    done_d      = 1'b0;
                    error_d     = 1'b0;
                    lp_clr_s    = 1'b1;
                    rst_cnt_d   = RST_LOAD;
                    wait_d      = 16'd0;
                    if (file_size == 16'd0) begin
                        state_d = ST_ERR;
                        error_d = 1'b1;
                    end else begin
                        state_d = ST_RST;
                    end
                end else begin
                    state_d = state_q;
                end
            end

            ST_RST: begin
                if (rst_cnt_q == 16'd0) begin
                    state_d = ST_FILL;
                end else begin
                    rst_cnt_d = rst_cnt_q - 16'd1;
                end
            end

            ST_FILL: begin
                if (byte_valid) begin
                    lp_wr_s     = 1'b1;
                    remaining_d = remaining_q - 16'd1;
                    if (remaining_q == 16'd1) begin
                        // Last byte of the image: pad the unwritten lanes now.
                        lp_pad_s = 1'b1;
                        state_d  = ST_REQ;
                        wait_d   = 16'd0;
                    end else if (lane_s == LANE_LAST) begin
                        state_d = ST_REQ;
                        wait_d  = 16'd0;
                    end else begin
                        state_d = ST_FILL;
                    end
                end else begin
                    state_d = ST_FILL;
                end
            end

            ST_REQ: begin
                if (host_bootdata_ack) begin
                    state_d = ST_REL;
                    wait_d  = 16'd0;
                end else if (wait_q >= ACK_LIMIT) begin
                    state_d = ST_ERR;
                    error_d = 1'b1;
                end else begin
                    wait_d = wait_q + 16'd1;
                end
            end

            ST_REL: begin
                if (!host_bootdata_ack) begin
                    if (remaining_q == 16'd0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d     = ST_FILL;
                        lp_preset_s = 1'b1;
                    end
                end else if (wait_q >= ACK_LIMIT) begin
                    state_d = ST_ERR;
                    error_d = 1'b1;
                end else begin
                    wait_d = wait_q + 16'd1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Controller state, counters and sticky status registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            remaining_q <= 16'd0;
            wait_q      <= 16'd0;
            rst_cnt_q   <= 16'd0;
            size_q      <= 16'd0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            wait_q      <= wait_d;
            rst_cnt_q   <= rst_cnt_d;
            size_q      <= size_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    // Registered handshake and status strobes decoded from the next state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req_q     <= 1'b0;
            ready_q   <= 1'b0;
            rst_out_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            req_q     <= (state_d == ST_REQ);
            ready_q   <= (state_d == ST_FILL);
            rst_out_q <= (state_d == ST_RST);
            busy_q    <= (state_d == ST_RST) || (state_d == ST_FILL) ||
                         (state_d == ST_REQ) || (state_d == ST_REL);
        end
    end

    assign byte_ready          = ready_q;
    assign host_bootdata       = word_s;
    assign host_bootdata_req   = req_q;
    assign host_bootdata_reset = rst_out_q;
    assign host_bootdata_size  = size_q;
    assign busy                = busy_q;
    assign done                = done_q;
    assign error               = error_q;

endmodule

// File: tb/tb_boot_word_packer.sv
// Directed bench for boot_word_packer: continuous and padded loads, throttled
// bytes with a slow loader, handshake timeout, mid-handshake reset and
// zero-size start. A second instance uses a short ack timeout.
module tb_boot_word_packer;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [15:0] file_size;
    logic [7:0]  byte_data;
    logic        byte_valid;
    logic        byte_ready;
    logic [31:0] host_bootdata;
    logic        host_bootdata_req;
    logic        host_bootdata_ack;
    logic        host_bootdata_reset;
    logic [15:0] host_bootdata_size;
    logic        busy;
    logic        done;
    logic        error;

    logic        t_start;
    logic [15:0] t_file_size;
    logic [7:0]  t_byte_data;
    logic        t_byte_valid;
    logic        t_byte_ready;
    logic [31:0] t_bootdata;
    logic        t_req;
    logic        t_ack;
    logic        t_rst_out;
    logic [15:0] t_size;
    logic        t_busy;
    logic        t_done;
    logic        t_error;

    int          n_chk = 0;
    int          n_err = 0;
    logic [31:0] words[$];
    int          req_pulses;
    int          accepted;

    boot_word_packer u_dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .start               (start),
        .file_size           (file_size),
        .byte_data           (byte_data),
        .byte_valid          (byte_valid),
        .byte_ready          (byte_ready),
        .host_bootdata       (host_bootdata),
        .host_bootdata_req   (host_bootdata_req),
        .host_bootdata_ack   (host_bootdata_ack),
        .host_bootdata_reset (host_bootdata_reset),
        .host_bootdata_size  (host_bootdata_size),
        .busy                (busy),
        .done                (done),
        .error               (error)
    );

    boot_word_packer #(
        .ACK_TIMEOUT (16'd16)
    ) u_to (
        .clk                 (clk),
        .reset_n             (reset_n),
        .start               (t_start),
        .file_size           (t_file_size),
        .byte_data           (t_byte_data),
        .byte_valid          (t_byte_valid),
        .byte_ready          (t_byte_ready),
        .host_bootdata       (t_bootdata),
        .host_bootdata_req   (t_req),
        .host_bootdata_ack   (t_ack),
        .host_bootdata_reset (t_rst_out),
        .host_bootdata_size  (t_size),
        .busy                (t_busy),
        .done                (t_done),
        .error               (t_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the edge that samples start.
    task automatic do_start(input logic [15:0] sz);
        file_size = sz;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Feeds bytes 01,02,... and acts as the loader until done/error or budget.
    task automatic run_load(input int nb, input bit tog, input int ack_dly,
                            input int inj_cyc, input int budget);
        int          idx   = 0;
        int          cyc   = 0;
        int          dcnt  = 0;
        int          acc4  = -1;
        int          rise1 = -1;
        bit          prev_req = 1'b0;
        bit          fin   = 1'b0;
        logic [31:0] held  = 32'd0;
        words.delete();
        req_pulses = 0;
        accepted   = 0;
        byte_data  = 8'h01;
        byte_valid = tog ? 1'b0 : 1'b1;
        while (!fin && cyc < budget) begin
            @(posedge clk);
            cyc++;
            if (byte_valid && byte_ready) begin
                check("accept_in_fill",
                      {29'd0, host_bootdata_req, host_bootdata_reset, busy}, 32'd1);
                idx++;
                accepted++;
                if (idx == 4) acc4 = cyc;
            end
            #1;
            if (cyc == inj_cyc) begin
                file_size = 16'h0033;
                start     = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (host_bootdata_req && !prev_req) begin
                words.push_back(host_bootdata);
                req_pulses++;
                held = host_bootdata;
                if (rise1 < 0) rise1 = cyc;
            end else if (host_bootdata_req) begin
                check("word_stable", host_bootdata, held);
            end
            prev_req = host_bootdata_req;
            if (host_bootdata_req && !host_bootdata_ack) begin
                if (dcnt >= ack_dly) begin
                    host_bootdata_ack = 1'b1;
                    dcnt = 0;
                end else begin
                    dcnt++;
                end
            end else if (!host_bootdata_req && host_bootdata_ack) begin
                host_bootdata_ack = 1'b0;
            end
            byte_data  = 8'(idx + 1);
            byte_valid = (idx < nb) && (tog ? cyc[0] : 1'b1);
            fin = done || error;
        end
        byte_valid        = 1'b0;
        host_bootdata_ack = 1'b0;
        start             = 1'b0;
        check("load_finished", {31'd0, fin}, 32'd1);
        if (nb >= 4) check("req_latency", rise1, acc4);
    endtask

    initial begin
        int  cnt;
        int  idx;
        bit  rst_seen;

        reset_n = 1'b0;
        start = 1'b0; file_size = 16'd0; byte_data = 8'd0; byte_valid = 1'b0;
        host_bootdata_ack = 1'b0;
        t_start = 1'b0; t_file_size = 16'd0; t_byte_data = 8'hAA;
        t_byte_valid = 1'b0; t_ack = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_word", host_bootdata, 32'd0);
        check("rst_size", {16'd0, host_bootdata_size}, 32'd0);
        check("rst_flags", {25'd0, host_bootdata_req, host_bootdata_reset, byte_ready,
                            busy, done, error, 1'b0}, 32'd0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Load 1: 8 bytes, continuous, immediate ack.
        do_start(16'd8);
        check("l1_rst_pulse", {31'd0, host_bootdata_reset}, 32'd1);
        check("l1_ready_in_rst", {31'd0, byte_ready}, 32'd0);
        check("l1_busy", {31'd0, busy}, 32'd1);
        check("l1_size_latched", {16'd0, host_bootdata_size}, 32'd8);
        repeat (3) @(posedge clk);
        #1;
        check("l1_rst_pulse_end", {31'd0, host_bootdata_reset}, 32'd1);
        @(posedge clk);
        #1;
        check("l1_rst_dropped", {31'd0, host_bootdata_reset}, 32'd0);
        check("l1_ready_up", {31'd0, byte_ready}, 32'd1);
        run_load(8, 1'b0, 0, -1, 200);
        check("l1_nwords", req_pulses, 32'd2);
        check("l1_word0", words[0], 32'h01020304);
        check("l1_word1", words[1], 32'h05060708);
        check("l1_accepted", accepted, 32'd8);
        check("l1_done_busy_err", {29'd0, done, busy, error}, 32'b100);
        check("l1_size", {16'd0, host_bootdata_size}, 32'd8);

        // Load 2: 6 bytes, padded second word, restarted from DONE.
        do_start(16'd6);
        check("l2_done_cleared", {31'd0, done}, 32'd0);
        run_load(6, 1'b0, 0, -1, 200);
        check("l2_nwords", req_pulses, 32'd2);
        check("l2_word0", words[0], 32'h01020304);
        check("l2_word1", words[1], 32'h0506FFFF);
        check("l2_done", {31'd0, done}, 32'd1);

        // Load 3: throttled bytes, slow loader, ignored second start.
        do_start(16'd5);
        run_load(5, 1'b1, 20, 10, 400);
        check("l3_nwords", req_pulses, 32'd2);
        check("l3_word0", words[0], 32'h01020304);
        check("l3_word1", words[1], 32'h05FFFFFF);
        check("l3_accepted", accepted, 32'd5);
        check("l3_size_kept", {16'd0, host_bootdata_size}, 32'd5);
        check("l3_done_err", {30'd0, done, error}, 32'b10);

        // Timeout instance: ack tied low, error 16 clocks after req rises.
        t_file_size  = 16'd4;
        t_start      = 1'b1;
        t_byte_valid = 1'b1;
        @(posedge clk);
        #1;
        t_start = 1'b0;
        cnt = 0;
        while (!t_req && cnt < 30) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        check("to_req_seen", {31'd0, t_req}, 32'd1);
        check("to_word", t_bootdata, 32'hAAAAAAAA);
        cnt = 0;
        while (!t_error && cnt < 40) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        t_byte_valid = 1'b0;
        check("to_latency", cnt, 32'd16);
        check("to_flags", {28'd0, t_req, t_byte_ready, t_busy, t_done}, 32'd0);

        // Reset asserted while a word is awaiting ack.
        do_start(16'd4);
        byte_valid = 1'b1;
        idx = 0;
        byte_data = 8'h01;
        cnt = 0;
        while (!host_bootdata_req && cnt < 30) begin
            @(posedge clk);
            if (byte_valid && byte_ready) idx++;
            #1;
            byte_data = 8'(idx + 1);
            cnt++;
        end
        byte_valid = 1'b0;
        check("rq_req_seen", {31'd0, host_bootdata_req}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("rq_async_drop", {29'd0, host_bootdata_req, busy, byte_ready}, 32'd0);
        check("rq_word_cleared", host_bootdata, 32'd0);
        check("rq_size_cleared", {16'd0, host_bootdata_size}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("rq_idle", {29'd0, busy, done, error}, 32'd0);
        do_start(16'd3);
        run_load(3, 1'b0, 0, -1, 200);
        check("rq_nwords", req_pulses, 32'd1);
        check("rq_word0", words[0], 32'h010203FF);
        check("rq_done", {31'd0, done}, 32'd1);

        // Zero-size start: error, no reset pulse.
        do_start(16'd0);
        rst_seen = host_bootdata_reset;
        check("z_error", {29'd0, error, done, busy}, 32'b100);
        check("z_size", {16'd0, host_bootdata_size}, 32'd0);
        repeat (5) begin
            @(posedge clk);
            #1;
            rst_seen = rst_seen | host_bootdata_reset;
        end
        check("z_no_rst_pulse", {31'd0, rst_seen}, 32'd0);
        check("z_error_sticky", {31'd0, error}, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
